hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, number of cycles IF/ID and ID/EX are flushed after a mispredict; legal range 1..3.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 id_rs1  input  5  rs1 of instruction in ID.
REQ-005 id_rs2  input  5  rs2 of instruction in ID.
REQ-006 ex_mem_read  input  1  instruction in EX is a load.
REQ-007 ex_wb_rd  input  5  destination register of instruction in EX.
REQ-008 ex_mispredict  input  1  EX branch/jump resolution disagrees with prediction.
REQ-009 ex_forward_pipeline_flush  input  1  instruction in EX is a flush bubble.
REQ-010 mem_busy  input  1  data memory not ready; whole pipeline must freeze.
REQ-011 pc_en  output  1  PC update enable.
REQ-012 if_id_en / if_id_flush  output  1 each  IF/ID register enable / flush.
REQ-013 id_ex_en / id_ex_flush  output  1 each  ID/EX register enable / flush (drives pipeline_en / pipeline_flush).
REQ-014 ex_mem_en  output  1  EX/MEM register enable.

Function
REQ-015 FSM states RUN, FLUSH, HOLD; 2-bit flush counter; 1-bit pending_flush register.
REQ-016 Outputs are combinational from state, counter and current inputs; zero-latency response in the cycle a condition is visible.
REQ-017 Load-use hazard = ex_mem_read && ex_wb_rd!=0 && (ex_wb_rd==id_rs1 || ex_wb_rd==id_rs2); ex_wb_rd==0 never stalls.
REQ-018 Valid mispredict = ex_mispredict && !ex_forward_pipeline_flush; mispredict from a bubble is ignored.
REQ-019 Priority: mem_busy > valid mispredict > load-use.
REQ-020 RUN, no condition: all *_en=1, all *_flush=0; stay RUN.
REQ-021 RUN, load-use: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1, ex_mem_en=1; stay RUN (exactly one bubble per load).
REQ-022 RUN, valid mispredict: pc_en=1, if_id_flush=1, id_ex_flush=1; if FLUSH_CYCLES>1 go FLUSH with counter=FLUSH_CYCLES-1, else stay RUN.
REQ-023 FLUSH: if_id_flush=1, id_ex_flush=1, pc_en=1; decrement counter; return to RUN when counter reaches 1 on this cycle; load-use ignored in FLUSH.
REQ-024 Any state, mem_busy=1: all *_en=0, all *_flush=0; go HOLD; counter frozen.
REQ-025 Valid mispredict while mem_busy=1 sets pending_flush; it does not flush while frozen.
REQ-026 HOLD with mem_busy=0: if pending_flush, perform REQ-022 behaviour this cycle and clear pending_flush; else resume saved state (RUN or FLUSH with frozen counter).
REQ-027 Flush and enable of the same register never both cause a load; flush wins in the target register.

Reset
REQ-028 While rst=1: state=RUN, counter=0, pending_flush=0, all *_en=0, all *_flush=0, performance counters 0.
REQ-029 Reset mid-FLUSH or mid-HOLD discards remaining flush cycles and pending_flush.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: outputs stall_cycles[31:0] (cycles with pc_en=0, rst=0) and flush_events[31:0] (valid mispredicts actioned), both wrap at 2^32.
REQ-031 Macro undefined: these ports and counters do not exist; all other behaviour identical.

Structure
REQ-032 FSM state encoding and FLUSH_CYCLES range constants live in shared package riscv_ctrl_pkg; opcode/ALU defines remain in existing shared defines.
REQ-033 Optional sub-module hazard_perf_cnt holds the two counters; instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-034 Load x5 in EX (ex_mem_read=1, ex_wb_rd=5), id_rs2=5 -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle.
REQ-035 ex_mem_read=1, ex_wb_rd=0, id_rs1=0 -> no stall, all enables 1.
REQ-036 FLUSH_CYCLES=2, ex_mispredict pulse 1 cycle -> if_id_flush=id_ex_flush=1 for 2 consecutive cycles, then RUN.
REQ-037 ex_mispredict=1 with ex_forward_pipeline_flush=1 -> no flush, flush_events unchanged.
REQ-038 mem_busy high 3 cycles with mispredict in 1st -> all enables 0 for 3 cycles, flush asserted on 4th cycle, flush_events +1.
REQ-039 rst asserted during FLUSH (FLUSH_CYCLES=3) -> outputs 0 immediately; after release RUN, no residual flush.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared pipeline-control types: hazard FSM state encoding and flush-length limits.
package riscv_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StFlush = 2'd1,
        StHold  = 2'd2
    } hazard_state_e;

    localparam int unsigned FlushCyclesMin = 1;
    localparam int unsigned FlushCyclesMax = 3;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running stall-cycle and actioned-flush counters for hazard_ctrl; both wrap at 2^32.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush_event,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (stall) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush_event) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, mispredict flush, memory-busy freeze.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_events counters.
module hazard_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_wb_rd,
    input  logic        ex_mispredict,
    input  logic        ex_forward_pipeline_flush,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        ex_mem_en
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    localparam logic [1:0] FlushReload = 2'(FLUSH_CYCLES - 1);

    hazard_state_e state_q, state_d, eff_state;
    logic [1:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          load_use, mis_valid, do_flush;

    assign load_use  = ex_mem_read && (ex_wb_rd != 5'd0) &&
                       ((ex_wb_rd == id_rs1) || (ex_wb_rd == id_rs2));
    assign mis_valid = ex_mispredict && !ex_forward_pipeline_flush;
    assign do_flush  = mis_valid || ((state_q == StHold) && pend_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        // HOLD remembers an interrupted flush only through a non-zero counter.
        eff_state   = state_q;
        if (state_q == StHold) begin
            eff_state = (cnt_q != 2'd0) ? StFlush : StRun;
        end

        if (rst) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (mem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            state_d   = StHold;
            pend_d    = pend_q | mis_valid;
        end else if (do_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pend_d      = 1'b0;
            if (FLUSH_CYCLES > 1) begin
                state_d = StFlush;
                cnt_d   = FlushReload;
            end else begin
                state_d = StRun;
                cnt_d   = 2'd0;
            end
        end else begin
            case (eff_state)
                StFlush: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (cnt_q <= 2'd1) begin
                        state_d = StRun;
                        cnt_d   = 2'd0;
                    end else begin
                        state_d = StFlush;
                        cnt_d   = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = StRun;
                    if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall        (!pc_en),
        .flush_event  (!rst && !mem_busy && do_flush),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; three instances cover FLUSH_CYCLES = 1, 2, 3.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_wb_rd = 5'd0;
    logic       ex_mem_read = 1'b0, ex_mispredict = 1'b0, ex_fwd_flush = 1'b0, mem_busy = 1'b0;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
    logic [5:0] o1, o2, o3;
    localparam logic [5:0] RunAll = 6'b110101;
    localparam logic [5:0] Stall  = 6'b000111;
    localparam logic [5:0] Flush  = 6'b111111;
    localparam logic [5:0] Zero   = 6'b000000;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall1, fe1, stall2, fe2, stall3, fe3;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_mem_read(ex_mem_read),
        .ex_wb_rd(ex_wb_rd), .ex_mispredict(ex_mispredict),
        .ex_forward_pipeline_flush(ex_fwd_flush), .mem_busy(mem_busy),
        .pc_en(o1[5]), .if_id_en(o1[4]), .if_id_flush(o1[3]), .id_ex_en(o1[2]),
        .id_ex_flush(o1[1]), .ex_mem_en(o1[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall1), .flush_events(fe1)
`endif
    );

    hazard_ctrl #(.FLUSH_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_mem_read(ex_mem_read),
        .ex_wb_rd(ex_wb_rd), .ex_mispredict(ex_mispredict),
        .ex_forward_pipeline_flush(ex_fwd_flush), .mem_busy(mem_busy),
        .pc_en(o2[5]), .if_id_en(o2[4]), .if_id_flush(o2[3]), .id_ex_en(o2[2]),
        .id_ex_flush(o2[1]), .ex_mem_en(o2[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall2), .flush_events(fe2)
`endif
    );

    hazard_ctrl #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_mem_read(ex_mem_read),
        .ex_wb_rd(ex_wb_rd), .ex_mispredict(ex_mispredict),
        .ex_forward_pipeline_flush(ex_fwd_flush), .mem_busy(mem_busy),
        .pc_en(o3[5]), .if_id_en(o3[4]), .if_id_flush(o3[3]), .id_ex_en(o3[2]),
        .id_ex_flush(o3[1]), .ex_mem_en(o3[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall3), .flush_events(fe3)
`endif
    );

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_wb_rd = 5'd0; ex_mem_read = 1'b0;
        ex_mispredict = 1'b0; ex_fwd_flush = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        mid();
        total_cnt++; if (o1 !== Zero) $display("FAIL reset_o1: got %b want %b", o1, Zero); else pass_cnt++;
        total_cnt++; if (o2 !== Zero) $display("FAIL reset_o2: got %b want %b", o2, Zero); else pass_cnt++;
        total_cnt++; if (o3 !== Zero) $display("FAIL reset_o3: got %b want %b", o3, Zero); else pass_cnt++;
        next();
        rst = 1'b0;
        mid();
        total_cnt++; if (o1 !== RunAll) $display("FAIL reset_release: got %b want %b", o1, RunAll); else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
        total_cnt++; if (fe1 !== 32'd0) $display("FAIL reset_fe: got %0d want 0", fe1); else pass_cnt++;
        total_cnt++; if (stall1 !== 32'd0) $display("FAIL reset_stall: got %0d want 0", stall1); else pass_cnt++;
`endif
        next();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1'b1; ex_wb_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
        mid();
        total_cnt++; if (o1 !== Stall) $display("FAIL load_use_rs2: got %b want %b", o1, Stall); else pass_cnt++;
        next();
        ex_mem_read = 1'b0;
        mid();
        total_cnt++; if (o1 !== RunAll) $display("FAIL load_use_one_bubble: got %b want %b", o1, RunAll); else pass_cnt++;
        next();
        ex_mem_read = 1'b1; ex_wb_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd1;
        mid();
        total_cnt++; if (o1 !== Stall) $display("FAIL load_use_rs1: got %b want %b", o1, Stall); else pass_cnt++;
        next();
        ex_mem_read = 1'b0;
        mid();
        total_cnt++; if (o1 !== RunAll) $display("FAIL non_load_match: got %b want %b", o1, RunAll); else pass_cnt++;
        next();
        ex_mem_read = 1'b1; ex_wb_rd = 5'd9; id_rs1 = 5'd8; id_rs2 = 5'd10;
        mid();
        total_cnt++; if (o1 !== RunAll) $display("FAIL load_no_match: got %b want %b", o1, RunAll); else pass_cnt++;
        next();
        idle();
    endtask

    task automatic test_x0();
        do_reset();
        ex_mem_read = 1'b1; ex_wb_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        mid();
        total_cnt++; if (o1 !== RunAll) $display("FAIL x0_no_stall: got %b want %b", o1, RunAll); else pass_cnt++;
        next();
        idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        ex_mispredict = 1'b1;
        mid();
        total_cnt++; if (o1 !== Flush) $display("FAIL mis_c0_fc1: got %b want %b", o1, Flush); else pass_cnt++;
        total_cnt++; if (o2 !== Flush) $display("FAIL mis_c0_fc2: got %b want %b", o2, Flush); else pass_cnt++;
        total_cnt++; if (o3 !== Flush) $display("FAIL mis_c0_fc3: got %b want %b", o3, Flush); else pass_cnt++;
        next();
        // load-use present: FC=1 is back in RUN and stalls, the others ignore it
        ex_mispredict = 1'b0; ex_mem_read = 1'b1; ex_wb_rd = 5'd5; id_rs2 = 5'd5;
        mid();
        total_cnt++; if (o1 !== Stall) $display("FAIL mis_c1_fc1: got %b want %b", o1, Stall); else pass_cnt++;
        total_cnt++; if (o2 !== Flush) $display("FAIL mis_c1_fc2: got %b want %b", o2, Flush); else pass_cnt++;
        total_cnt++; if (o3 !== Flush) $display("FAIL mis_c1_fc3: got %b want %b", o3, Flush); else pass_cnt++;
        next();
        idle();
        mid();
        total_cnt++; if (o2 !== RunAll) $display("FAIL mis_c2_fc2: got %b want %b", o2, RunAll); else pass_cnt++;
        total_cnt++; if (o3 !== Flush) $display("FAIL mis_c2_fc3: got %b want %b", o3, Flush); else pass_cnt++;
        next();
        mid();
        total_cnt++; if (o3 !== RunAll) $display("FAIL mis_c3_fc3: got %b want %b", o3, RunAll); else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
        total_cnt++; if (fe2 !== 32'd1) $display("FAIL mis_fe2: got %0d want 1", fe2); else pass_cnt++;
`endif
        next();
    endtask

    task automatic test_bubble();
        do_reset();
        ex_mispredict = 1'b1; ex_fwd_flush = 1'b1;
        mid();
        total_cnt++; if (o1 !== RunAll) $display("FAIL bubble_fc1: got %b want %b", o1, RunAll); else pass_cnt++;
        total_cnt++; if (o2 !== RunAll) $display("FAIL bubble_fc2: got %b want %b", o2, RunAll); else pass_cnt++;
        next();
        idle();
        mid();
        total_cnt++; if (o2 !== RunAll) $display("FAIL bubble_after_fc2: got %b want %b", o2, RunAll); else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
        total_cnt++; if (fe1 !== 32'd0) $display("FAIL bubble_fe1: got %0d want 0", fe1); else pass_cnt++;
`endif
        next();
    endtask

    task automatic test_mem_busy();
        do_reset();
        mem_busy = 1'b1; ex_mispredict = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            total_cnt++; if (o1 !== Zero) $display("FAIL busy_c%0d_fc1: got %b want %b", c, o1, Zero); else pass_cnt++;
            total_cnt++; if (o2 !== Zero) $display("FAIL busy_c%0d_fc2: got %b want %b", c, o2, Zero); else pass_cnt++;
            next();
            ex_mispredict = 1'b0;
        end
        mem_busy = 1'b0;
        mid();
        total_cnt++; if (o1 !== Flush) $display("FAIL busy_release_fc1: got %b want %b", o1, Flush); else pass_cnt++;
        total_cnt++; if (o2 !== Flush) $display("FAIL busy_release_fc2: got %b want %b", o2, Flush); else pass_cnt++;
        next();
        mid();
        total_cnt++; if (o1 !== RunAll) $display("FAIL busy_after_fc1: got %b want %b", o1, RunAll); else pass_cnt++;
        total_cnt++; if (o2 !== Flush) $display("FAIL busy_after_fc2: got %b want %b", o2, Flush); else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
        total_cnt++; if (fe1 !== 32'd1) $display("FAIL busy_fe1: got %0d want 1", fe1); else pass_cnt++;
        total_cnt++; if (stall1 !== 32'd3) $display("FAIL busy_stall1: got %0d want 3", stall1); else pass_cnt++;
`endif
        next();
        mid();
        total_cnt++; if (o2 !== RunAll) $display("FAIL busy_end_fc2: got %b want %b", o2, RunAll); else pass_cnt++;
        next();
    endtask

    task automatic test_hold_resume();
        do_reset();
        ex_mispredict = 1'b1;
        next();
        ex_mispredict = 1'b0; mem_busy = 1'b1; ex_mem_read = 1'b1; ex_wb_rd = 5'd4; id_rs1 = 5'd4;
        mid();
        total_cnt++; if (o3 !== Zero) $display("FAIL hold_frozen_fc3: got %b want %b", o3, Zero); else pass_cnt++;
        total_cnt++; if (o1 !== Zero) $display("FAIL hold_busy_over_load_fc1: got %b want %b", o1, Zero); else pass_cnt++;
        next();
        idle();
        for (int c = 0; c < 2; c++) begin
            mid();
            total_cnt++; if (o3 !== Flush) $display("FAIL hold_resume_c%0d_fc3: got %b want %b", c, o3, Flush); else pass_cnt++;
            next();
        end
        mid();
        total_cnt++; if (o3 !== RunAll) $display("FAIL hold_resume_end_fc3: got %b want %b", o3, RunAll); else pass_cnt++;
        next();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        ex_mispredict = 1'b1;
        next();
        ex_mispredict = 1'b0; rst = 1'b1;
        mid();
        total_cnt++; if (o3 !== Zero) $display("FAIL rst_in_flush_fc3: got %b want %b", o3, Zero); else pass_cnt++;
        next();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            mid();
            total_cnt++; if (o3 !== RunAll) $display("FAIL rst_no_residual_c%0d: got %b want %b", c, o3, RunAll); else pass_cnt++;
            next();
        end
        // pending flush captured during HOLD is dropped by reset
        mem_busy = 1'b1; ex_mispredict = 1'b1;
        next();
        idle(); rst = 1'b1;
        next();
        rst = 1'b0;
        mid();
        total_cnt++; if (o1 !== RunAll) $display("FAIL rst_drops_pending_fc1: got %b want %b", o1, RunAll); else pass_cnt++;
        next();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_mispredict();
        test_bubble();
        test_mem_busy();
        test_hold_resume();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
